de2_io_bridge: RTL and testbench

//   Board-side I/O bridge between the pipelined core's MMIO registers and the DE2 pins.

---
 rtl/de2_io_bridge.sv | 240 ++++++++++++++++++++++++
 tb/tb_de2_io_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/de2_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : de2_io_bridge
// Brief    : DE2 board bridge. Debounces slide switches into a 32-bit word and
//            turns CPU writes of the LCD register into HD44780-timed cycles.
//            Define LCD_QUEUE_EN for a one-entry pending LCD request buffer.
// Revision : 1.0 - initial release
// ============================================================================
module de2_io_bridge #(
    parameter int NUM_SW        = 17,
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int LCD_SETUP_CYC = 4,
    parameter int LCD_PULSE_CYC = 25,
    parameter int LCD_HOLD_CYC  = 2000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_SW-1:0] sw_raw_i,
    output logic [31:0]       sw_o,
    input  logic              lcd_req_i,
    input  logic [31:0]       lcd_word_i,
    output logic              lcd_busy_o,
    output logic              lcd_ovf_o,
    output logic [7:0]        lcd_data_o,
    output logic              lcd_rw_o,
    output logic              lcd_rs_o,
    output logic              lcd_en_o,
    output logic              lcd_on_o
);

    localparam int c_DCW = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_MAX_PHASE =
        (LCD_HOLD_CYC > LCD_PULSE_CYC) ?
            ((LCD_HOLD_CYC > LCD_SETUP_CYC) ? LCD_HOLD_CYC : LCD_SETUP_CYC) :
            ((LCD_PULSE_CYC > LCD_SETUP_CYC) ? LCD_PULSE_CYC : LCD_SETUP_CYC);
    localparam int c_LCW = $clog2(c_MAX_PHASE + 1);

    localparam logic [c_LCW-1:0] c_SETUP_LD = c_LCW'(LCD_SETUP_CYC - 1);
    localparam logic [c_LCW-1:0] c_PULSE_LD = c_LCW'(LCD_PULSE_CYC - 1);
    localparam logic [c_LCW-1:0] c_HOLD_LD  = c_LCW'(LCD_HOLD_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // ------------------------------------------------------------------ switches
    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] w_stable;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw_i;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_debounce
        logic [c_DCW-1:0] r_cnt;
        logic             r_stable;

        // Any return to the stable value restarts the qualification window.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else if (r_sync2[gi] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DCW'(DEBOUNCE_CYC - 1)) begin
                r_stable <= r_sync2[gi];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_DCW'(1);
            end
        end

        assign w_stable[gi] = r_stable;
    end

    always_comb begin
        sw_o             = '0;
        sw_o[NUM_SW-1:0] = w_stable;
    end

    // ----------------------------------------------------------------------- LCD
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_LCW-1:0] r_cnt;
    logic [c_LCW-1:0] w_cnt_nxt;
    logic             w_accept;
    logic [31:0]      w_acc_word;
    logic             w_ovf_set;
    logic             w_busy_nxt;
    logic             r_en;
    logic             r_busy;
    logic             r_ovf;
    logic [7:0]       r_data;
    logic             r_rw;
    logic             r_rs;
    logic             r_on;
`ifdef LCD_QUEUE_EN
    logic             r_pend_vld;
    logic             w_pend_vld_nxt;
    logic [31:0]      r_pend_word;
    logic [31:0]      w_pend_word_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_acc_word  = lcd_word_i;
        w_ovf_set   = 1'b0;
`ifdef LCD_QUEUE_EN
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_word_nxt = r_pend_word;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef LCD_QUEUE_EN
                // A buffered request wins; a fresh strobe this cycle refills the buffer.
                if (r_pend_vld) begin
                    w_accept        = 1'b1;
                    w_acc_word      = r_pend_word;
                    w_pend_vld_nxt  = lcd_req_i;
                    w_pend_word_nxt = lcd_word_i;
                end else begin
                    w_accept = lcd_req_i;
                end
`else
                w_accept = lcd_req_i;
`endif
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_SETUP_LD;
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = c_PULSE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_LCW'(1);
                end
            end
            S_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - c_LCW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - c_LCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if ((r_state != S_IDLE) && lcd_req_i) begin
`ifdef LCD_QUEUE_EN
            if (!r_pend_vld) begin
                w_pend_vld_nxt  = 1'b1;
                w_pend_word_nxt = lcd_word_i;
            end else begin
                w_ovf_set = 1'b1;
            end
`else
            w_ovf_set = 1'b1;
`endif
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
`ifdef LCD_QUEUE_EN
        w_busy_nxt = w_busy_nxt | w_pend_vld_nxt;
`endif
    end

    // EN and BUSY are registered from the next state so the pins never glitch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_data  <= '0;
            r_rw    <= 1'b0;
            r_rs    <= 1'b0;
            r_on    <= 1'b0;
`ifdef LCD_QUEUE_EN
            r_pend_vld  <= 1'b0;
            r_pend_word <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= (w_state_nxt == S_PULSE);
            r_busy  <= w_busy_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end
            if (w_accept) begin
                r_data <= w_acc_word[7:0];
                r_rw   <= w_acc_word[8];
                r_rs   <= w_acc_word[9];
                r_on   <= w_acc_word[31];
            end
`ifdef LCD_QUEUE_EN
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_word <= w_pend_word_nxt;
`endif
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, w_acc_word[30:10]};

    assign lcd_busy_o = r_busy;
    assign lcd_ovf_o  = r_ovf;
    assign lcd_data_o = r_data;
    assign lcd_rw_o   = r_rw;
    assign lcd_rs_o   = r_rs;
    assign lcd_en_o   = r_en;
    assign lcd_on_o   = r_on;

endmodule
`default_nettype wire

// File: tb/tb_de2_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_de2_io_bridge
// Brief    : Self-checking bench for de2_io_bridge with short debounce and LCD
//            timing; expectations follow LCD_QUEUE_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_de2_io_bridge;

    localparam int NSW = 17;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  data;
        logic        rw;
        logic        rs;
        logic        on;
    } lcd_vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSW-1:0]  sw_raw;
    logic [31:0]     sw;
    logic            req;
    logic [31:0]     word;
    logic            busy;
    logic            ovf;
    logic [7:0]      data;
    logic            rw;
    logic            rs;
    logic            en;
    logic            on;

    int              n_chk = 0;
    int              n_err = 0;
    lcd_vec_t        tbl[4];

    int              k;
    logic            prev_en;
    int              pulses;
    int              busy_cyc;
    logic [7:0]      hist[0:39];
    logic [7:0]      pulse_data[0:3];

    always #5 clk = ~clk;

    de2_io_bridge #(
        .NUM_SW        (NSW),
        .DEBOUNCE_CYC  (4),
        .LCD_SETUP_CYC (2),
        .LCD_PULSE_CYC (3),
        .LCD_HOLD_CYC  (5)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sw_raw_i   (sw_raw),
        .sw_o       (sw),
        .lcd_req_i  (req),
        .lcd_word_i (word),
        .lcd_busy_o (busy),
        .lcd_ovf_o  (ovf),
        .lcd_data_o (data),
        .lcd_rw_o   (rw),
        .lcd_rs_o   (rs),
        .lcd_en_o   (en),
        .lcd_on_o   (on)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Records one cycle of LCD activity for the back-to-back sequence.
    task automatic obs();
        if (busy) busy_cyc++;
        if (en && !prev_en) begin
            if (pulses < 4) pulse_data[pulses] = data;
            pulses++;
        end
        if (k < 40) hist[k] = data;
        prev_en = en;
        k++;
    endtask

    task automatic run_lcd(input lcd_vec_t v);
        req  = 1'b1;
        word = v.word;
        tick();
        req  = 1'b0;
        word = 32'hDEAD_BEEF;
        check("lcd_fields_accept", {data, rw, rs, on}, {v.data, v.rw, v.rs, v.on});
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            check("lcd_busy_en", {busy, en}, {(c < 10), (c >= 2 && c <= 4)});
        end
        check("lcd_fields_after", {data, rw, rs, on}, {v.data, v.rw, v.rs, v.on});
    endtask

    initial begin
        tbl[0] = '{word: 32'h8000_0241, data: 8'h41, rw: 1'b0, rs: 1'b1, on: 1'b1};
        tbl[1] = '{word: 32'h0000_0155, data: 8'h55, rw: 1'b1, rs: 1'b0, on: 1'b0};
        tbl[2] = '{word: 32'h8000_03FF, data: 8'hFF, rw: 1'b1, rs: 1'b1, on: 1'b1};
        tbl[3] = '{word: 32'h7FFF_FC00, data: 8'h00, rw: 1'b0, rs: 1'b0, on: 1'b0};

        rst    = 1'b1;
        sw_raw = '0;
        req    = 1'b0;
        word   = '0;
        tick();
        tick();
        check("reset_outputs", {sw, busy, ovf, data, rw, rs, en, on}, '0);
        rst = 1'b0;

        // Clean edge on switch 3: visible exactly 6 cycles later.
        sw_raw[3] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("debounce_wait", sw, 32'h0);
        end
        tick();
        check("debounce_sw3", sw, 32'h8);

        // 3-cycle glitch on switch 5 must be rejected.
        sw_raw[5] = 1'b1;
        tick();
        tick();
        tick();
        sw_raw[5] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("glitch_sw5", sw, 32'h8);
        end

        // All switches high: upper word bits stay zero.
        sw_raw = '1;
        for (int c = 1; c <= 5; c++) tick();
        check("all_sw_wait", sw, 32'h8);
        tick();
        check("all_sw", sw, 32'h0001_FFFF);

        for (int i = 0; i < 4; i++) run_lcd(tbl[i]);
        check("ovf_clear", ovf, 1'b0);

        // Back-to-back strobes while busy.
        k        = 0;
        prev_en  = 1'b0;
        pulses   = 0;
        busy_cyc = 0;
        req  = 1'b1;
        word = 32'h8000_0241;
        tick();
        obs();
        req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            obs();
        end
        req  = 1'b1;
        word = 32'h8000_0242;
        tick();
        obs();
        req = 1'b0;
`ifdef LCD_QUEUE_EN
        check("b2b_ovf_second", ovf, 1'b0);
`else
        check("b2b_ovf_second", ovf, 1'b1);
`endif
        req  = 1'b1;
        word = 32'h8000_0243;
        tick();
        obs();
        req = 1'b0;
        check("b2b_ovf_third", ovf, 1'b1);
        for (int c = 0; c < 30; c++) begin
            tick();
            obs();
        end
        check("b2b_first_pulse", pulse_data[0], 8'h41);
        check("b2b_hold_data", hist[9], 8'h41);
`ifdef LCD_QUEUE_EN
        check("b2b_pulses", pulses, 2);
        check("b2b_second_pulse", pulse_data[1], 8'h42);
        check("b2b_second_data", hist[11], 8'h42);
        check("b2b_busy_cycles", busy_cyc, 21);
`else
        check("b2b_pulses", pulses, 1);
        check("b2b_final_data", hist[25], 8'h41);
        check("b2b_busy_cycles", busy_cyc, 10);
`endif
        check("b2b_idle", busy, 1'b0);

        // Reset in the middle of the EN pulse.
        req  = 1'b1;
        word = tbl[1].word;
        tick();
        req = 1'b0;
        tick();
        tick();
        check("mid_pulse_en", en, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_reset", {busy, ovf, data, rw, rs, en, on}, '0);
        rst = 1'b0;
        run_lcd(tbl[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
